multicycle_control: RTL and testbench



---
 rtl/rv_pkg.sv | 45 ++++
 rtl/alu_decoder.sv | 64 ++++++
 rtl/multicycle_control.sv | 98 +++++++++
 tb/tb_multicycle_control.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32I encodings: opcodes, funct fields, ALU op codes and the
// multicycle controller state encoding. The ALU imports the same op codes.
package rv_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SLT = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_SUB = 4'b0110,
        ALU_SRL = 4'b1000,
        ALU_SLL = 4'b1001,
        ALU_SRA = 4'b1010
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IF  = 3'd0,
        ST_ID  = 3'd1,
        ST_EX  = 3'd2,
        ST_MEM = 3'd3,
        ST_WB  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Combinational instruction decoder: maps opcode/funct3/funct7 to an ALU op
// and flags anything outside the supported RV32I subset as illegal.
module alu_decoder
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       illegal
);

    logic f7Base;
    logic f7Alt;

    assign f7Base = (funct7 == F7_BASE);
    assign f7Alt  = (funct7 == F7_ALT);

    // Illegal encodings fall through with ADD so the ALU stays in a benign mode
    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        case (opcode)
            OPC_R: begin
                case (funct3)
                    F3_ADD: if (f7Base) alu_op = ALU_ADD;
                            else if (f7Alt) alu_op = ALU_SUB;
                            else illegal = 1'b1;
                    F3_SLL: if (f7Base) alu_op = ALU_SLL; else illegal = 1'b1;
                    F3_SLT: if (f7Base) alu_op = ALU_SLT; else illegal = 1'b1;
                    F3_XOR: if (f7Base) alu_op = ALU_XOR; else illegal = 1'b1;
                    F3_OR:  if (f7Base) alu_op = ALU_OR;  else illegal = 1'b1;
                    F3_AND: if (f7Base) alu_op = ALU_AND; else illegal = 1'b1;
                    F3_SR:  if (f7Base) alu_op = ALU_SRL;
                            else if (f7Alt) alu_op = ALU_SRA;
                            else illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_I: begin
                case (funct3)
                    F3_ADD: alu_op = ALU_ADD;
                    F3_SLT: alu_op = ALU_SLT;
                    F3_XOR: alu_op = ALU_XOR;
                    F3_OR:  alu_op = ALU_OR;
                    F3_AND: alu_op = ALU_AND;
                    F3_SLL: if (f7Base) alu_op = ALU_SLL; else illegal = 1'b1;
                    F3_SR:  if (f7Base) alu_op = ALU_SRL;
                            else if (f7Alt) alu_op = ALU_SRA;
                            else illegal = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_LOAD:   illegal = (funct3 != F3_LW);
            OPC_STORE:  illegal = (funct3 != F3_SW);
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) alu_op = ALU_SUB;
                else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Five-state (IF/ID/EX/MEM/WB) control unit for the multicycle RV32I datapath.
// Every strobe is derived from the registered state and the captured IR only.
module multicycle_control
    import rv_pkg::*;
#(
    parameter logic [2:0] RESET_STATE = 3'd0
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    output logic [3:0]  alu_op,
    output logic        alu_src,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        load_pc,
    output logic        pc_src,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t      stateQ;
    state_t      stateNext;
    logic [31:0] ir;
    logic        branchTaken;
    logic [3:0]  decOp;
    logic        decIllegal;
    logic        isR, isI, isLw, isSw, isBeq;
    logic        inExec;

    alu_decoder uDecoder (
        .opcode  (ir[6:0]),
        .funct3  (ir[14:12]),
        .funct7  (ir[31:25]),
        .alu_op  (decOp),
        .illegal (decIllegal)
    );

    assign isR   = ~decIllegal & (ir[6:0] == OPC_R);
    assign isI   = ~decIllegal & (ir[6:0] == OPC_I);
    assign isLw  = ~decIllegal & (ir[6:0] == OPC_LOAD);
    assign isSw  = ~decIllegal & (ir[6:0] == OPC_STORE);
    assign isBeq = ~decIllegal & (ir[6:0] == OPC_BRANCH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ      <= state_t'(RESET_STATE);
            ir          <= '0;
            branchTaken <= 1'b0;
        end else begin
            stateQ <= stateNext;
            if (stateQ == ST_IF) ir <= instr;
            if (stateQ == ST_EX) branchTaken <= isBeq & zero;
        end
    end

    always_comb begin
        stateNext = ST_IF;
        case (stateQ)
            ST_IF:   stateNext = ST_ID;
            ST_ID:   stateNext = ST_EX;
            ST_EX:   stateNext = ST_MEM;
            ST_MEM:  stateNext = ST_WB;
            ST_WB:   stateNext = ST_IF;
            default: stateNext = ST_IF;
        endcase
    end

    assign inExec = (stateQ == ST_EX) | (stateQ == ST_MEM) | (stateQ == ST_WB);

    // Strobes: write enables are confined to MEM (store) and WB (register/PC)
    always_comb begin
        alu_op     = ALU_ADD;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        load_pc    = 1'b0;
        pc_src     = 1'b0;
        illegal    = 1'b0;
        if (inExec) begin
            alu_op  = decOp;
            alu_src = isI | isLw | isSw;
        end
        if (stateQ == ST_MEM) mem_write = isSw;
        if (stateQ == ST_WB) begin
            reg_write  = isR | isI | isLw;
            mem_to_reg = isLw;
            load_pc    = 1'b1;
            pc_src     = branchTaken;
            illegal    = decIllegal;
        end
    end

    assign state = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control against a table-driven
// model of the supported instruction set and the five-cycle control schedule.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        zero;
    logic [3:0]  alu_op;
    logic        alu_src, mem_write, mem_to_reg, reg_write, load_pc, pc_src, illegal;
    logic [2:0]  state;

    int nChecks = 0;
    int nFails  = 0;
    int rTab[int];
    int iTab[int];

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .instr      (instr),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .load_pc    (load_pc),
        .pc_src     (pc_src),
        .illegal    (illegal),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] observedVec();
        return {2'b00, state, alu_op, alu_src, mem_write, mem_to_reg, reg_write, load_pc, pc_src, illegal};
    endfunction

    // Expected output vector for cycle k (0=IF .. 4=WB) of instruction ins
    function automatic logic [15:0] expectVec(input logic [31:0] ins, input int k, input bit taken);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        bit legal, isR, isI, isL, isS, isB, f7ok;
        int op, key;
        bit src, mw, m2r, rw, lp, ps, ill;
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        legal = 0; isR = 0; isI = 0; isL = 0; isS = 0; isB = 0;
        op   = 2;
        f7ok = (f7 == 7'h00) || (f7 == 7'h20);
        key  = (f7 == 7'h20 ? 8 : 0) + int'(f3);
        if (opc == 7'h33 && f7ok && rTab.exists(key)) begin
            legal = 1; isR = 1; op = rTab[key];
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
                if (f7ok && iTab.exists(key)) begin legal = 1; isI = 1; op = iTab[key]; end
            end else if (iTab.exists(int'(f3))) begin
                legal = 1; isI = 1; op = iTab[int'(f3)];
            end
        end else if (opc == 7'h03 && f3 == 3'd2) begin
            legal = 1; isL = 1;
        end else if (opc == 7'h23 && f3 == 3'd2) begin
            legal = 1; isS = 1;
        end else if (opc == 7'h63 && f3 == 3'd0) begin
            legal = 1; isB = 1; op = 6;
        end
        if (k < 2) return {2'b00, 3'(k), 4'b0010, 7'b0};
        src = isI | isL | isS;
        mw  = (k == 3) && isS;
        m2r = (k == 4) && isL;
        rw  = (k == 4) && (isR | isI | isL);
        lp  = (k == 4);
        ps  = (k == 4) && isB && taken;
        ill = (k == 4) && !legal;
        return {2'b00, 3'(k), 4'(op), src, mw, m2r, rw, lp, ps, ill};
    endfunction

    // Runs one instruction from an IF negedge through WB, checking every cycle
    task automatic applyStimulus(input logic [31:0] ins, input bit zeroVal, input bit randGarbage, input string tag);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("%s.c%0d", tag, k), observedVec(), expectVec(ins, k, zeroVal));
            checkOutput($sformatf("%s.ovl%0d", tag, k), {15'b0, mem_write & reg_write}, 16'h0000);
            instr = (k == 0) ? ins : (randGarbage ? $urandom : 32'hFFFF_FFFF);
            zero  = (k == 2) ? zeroVal : 1'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] w;
        rTab[0] = 4'b0010; rTab[8] = 4'b0110; rTab[7] = 4'b0000; rTab[6] = 4'b0001;
        rTab[4] = 4'b0101; rTab[2] = 4'b0100; rTab[1] = 4'b1001; rTab[5] = 4'b1000;
        rTab[13] = 4'b1010;
        iTab[0] = 4'b0010; iTab[7] = 4'b0000; iTab[6] = 4'b0001; iTab[4] = 4'b0101;
        iTab[2] = 4'b0100; iTab[1] = 4'b1001; iTab[5] = 4'b1000; iTab[13] = 4'b1010;

        rst = 1'b0; instr = 32'h0; zero = 1'b0;
        #1 checkOutput("resetAsync", observedVec(), expectVec(32'h0, 0, 0));
        repeat (3) @(negedge clk);
        checkOutput("resetHeld", observedVec(), expectVec(32'h0, 0, 0));
        rst = 1'b1;

        applyStimulus(32'h402081B3, 1'b0, 1'b0, "sub");
        applyStimulus(32'h4032D293, 1'b0, 1'b0, "srai");
        applyStimulus(32'h40329293, 1'b0, 1'b0, "slliAlt");
        applyStimulus(32'h0232D293, 1'b0, 1'b0, "srliBadF7");
        applyStimulus(32'h0080A203, 1'b1, 1'b0, "lw");
        applyStimulus(32'h0040A623, 1'b1, 1'b0, "sw");
        applyStimulus(32'h00208463, 1'b1, 1'b0, "beqTaken");
        applyStimulus(32'h00208463, 1'b0, 1'b0, "beqNot");

        // Abandon a sub in EX: everything must drop to the reset view at once
        instr = 32'h402081B3;
        @(negedge clk);
        instr = 32'hFFFF_FFFF;
        @(negedge clk);
        checkOutput("midEx.pre", {13'b0, state}, 16'd2);
        #2 rst = 1'b0;
        #1 checkOutput("midEx.rst", observedVec(), expectVec(32'h0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(32'h00208463, 1'b1, 1'b1, "beqAfterRst");

        for (int n = 0; n < 40; n++) begin
            w = $urandom;
            case ($urandom_range(0, 5))
                0: w[6:0] = 7'h33;
                1: w[6:0] = 7'h13;
                2: w[6:0] = 7'h03;
                3: w[6:0] = 7'h23;
                4: w[6:0] = 7'h63;
                default: ;
            endcase
            case ($urandom_range(0, 2))
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) w[14:12] = (w[6:0] == 7'h63) ? 3'd0 : 3'd2;
            applyStimulus(w, 1'($urandom), 1'b1, $sformatf("rnd%0d", n));
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
